anton_neopixel_frame_sched: RTL

//  Frame scheduler and pixel-RAM arbiter for the NeoPixel strip. Shares one single-port
//  8-bit pixel RAM between the bus master (read/write) and the serializer byte fetcher.

---
 rtl/anton_neopixel_frame_sched.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/anton_neopixel_frame_sched.sv
// Frame scheduler for the NeoPixel strip: arbitrates a single-port pixel RAM between
// the bus and the byte streamer, and sequences fetch/present/latch for each frame.
`timescale 1ns/1ps
module anton_neopixel_frame_sched #(
  parameter int PIXELS_MAX  = 66,
  parameter int RESET_DELAY = 600,
  localparam int PIXELS_BITS = $clog2(PIXELS_MAX)
) (
  input  logic                   clk10mhz,
  input  logic                   reset,
  input  logic [PIXELS_BITS-1:0] busAddr,
  input  logic [7:0]             busDataIn,
  input  logic                   busWrite,
  input  logic                   busRead,
  output logic                   busReady,
  output logic [7:0]             busDataOut,
  output logic                   busDataValid,
  input  logic                   ctrlStart,
  input  logic                   ctrlAuto,
  output logic                   ctrlBusy,
  output logic                   ctrlDone,
  output logic [PIXELS_BITS-1:0] ramAddr,
  output logic                   ramWe,
  output logic [7:0]             ramWdata,
  input  logic [7:0]             ramRdata,
  output logic [7:0]             pixData,
  output logic                   pixValid,
  input  logic                   pixReady,
  output logic                   neoLatch
);

  localparam int CNT_BITS = $clog2(RESET_DELAY + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_RDWAIT  = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_LATCH   = 3'd4;

  // One extra bit so the range check still works when PIXELS_MAX is a power of two.
  localparam logic [PIXELS_BITS:0]   PIX_LIMIT = (PIXELS_BITS + 1)'(PIXELS_MAX);
  localparam logic [PIXELS_BITS-1:0] PIX_LAST  = PIXELS_BITS'(PIXELS_MAX - 1);
  localparam logic [CNT_BITS-1:0]    CNT_LAST  = CNT_BITS'(RESET_DELAY - 1);

  logic [2:0]             state_reg, state_next;
  logic [PIXELS_BITS-1:0] index_reg, index_next;
  logic [CNT_BITS-1:0]    counter_reg, counter_next;
  logic                   start_pending_reg, start_pending_next;
  logic                   dirty_reg, dirty_next;
  logic [7:0]             pix_data_reg, pix_data_next;
  logic                   done_reg, done_next;
  logic                   rd_pending_reg;
  logic                   rd_oob_reg;
  logic [7:0]             bus_data_reg;
  logic                   bus_valid_reg;

  logic bus_grant;
  logic bus_req;
  logic bus_in_range;
  logic wr_accept;
  logic rd_accept;

  // The streamer only needs the port in FETCH; every other state belongs to the bus.
  assign bus_grant    = (state_reg != S_FETCH);
  assign bus_req      = busWrite | busRead;
  assign bus_in_range = ({1'b0, busAddr} < PIX_LIMIT);
  assign wr_accept    = bus_grant & busWrite;
  assign rd_accept    = bus_grant & busRead & ~busWrite;

  assign busReady     = bus_grant & bus_req;
  assign ramWe        = wr_accept & bus_in_range;
  assign ramWdata     = ramWe ? busDataIn : 8'h00;
  assign busDataOut   = bus_data_reg;
  assign busDataValid = bus_valid_reg;
  assign ctrlBusy     = (state_reg != S_IDLE);
  assign ctrlDone     = done_reg;
  assign pixData      = pix_data_reg;
  assign pixValid     = (state_reg == S_PRESENT);
  assign neoLatch     = (state_reg == S_LATCH);

  always_comb begin
    ramAddr = '0;
    if (state_reg == S_FETCH) begin
      ramAddr = index_reg;
    end else if (bus_req) begin
      ramAddr = busAddr;
    end
  end

  always_comb begin
    state_next         = state_reg;
    index_next         = index_reg;
    counter_next       = counter_reg;
    start_pending_next = start_pending_reg;
    dirty_next         = dirty_reg;
    pix_data_next      = pix_data_reg;
    done_next          = 1'b0;

    if (ctrlStart) begin
      start_pending_next = 1'b1;
    end
    if (ramWe) begin
      dirty_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (start_pending_reg | ctrlStart | (ctrlAuto & dirty_reg)) begin
          state_next         = S_FETCH;
          start_pending_next = 1'b0;
          dirty_next         = 1'b0;
          index_next         = '0;
        end
      end
      S_FETCH: begin
        state_next = S_RDWAIT;
      end
      S_RDWAIT: begin
        pix_data_next = ramRdata;
        state_next    = S_PRESENT;
      end
      S_PRESENT: begin
        if (pixReady) begin
          if (index_reg == PIX_LAST) begin
            index_next   = '0;
            counter_next = '0;
            state_next   = S_LATCH;
          end else begin
            index_next = index_reg + PIXELS_BITS'(1);
            state_next = S_FETCH;
          end
        end
      end
      S_LATCH: begin
        if (counter_reg == CNT_LAST) begin
          counter_next = '0;
          done_next    = 1'b1;
          state_next   = S_IDLE;
        end else begin
          counter_next = counter_reg + CNT_BITS'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk10mhz or posedge reset) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      index_reg         <= '0;
      counter_reg       <= '0;
      start_pending_reg <= 1'b0;
      dirty_reg         <= 1'b0;
      pix_data_reg      <= 8'h00;
      done_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      index_reg         <= index_next;
      counter_reg       <= counter_next;
      start_pending_reg <= start_pending_next;
      dirty_reg         <= dirty_next;
      pix_data_reg      <= pix_data_next;
      done_reg          <= done_next;
    end
  end

  // RAM data for an accepted read arrives one cycle later; capture it then.
  always_ff @(posedge clk10mhz or posedge reset) begin
    if (reset) begin
      rd_pending_reg <= 1'b0;
      rd_oob_reg     <= 1'b0;
      bus_data_reg   <= 8'h00;
      bus_valid_reg  <= 1'b0;
    end else begin
      rd_pending_reg <= rd_accept;
      rd_oob_reg     <= ~bus_in_range;
      bus_valid_reg  <= rd_pending_reg;
      if (rd_pending_reg) begin
        bus_data_reg <= rd_oob_reg ? 8'h00 : ramRdata;
      end
    end
  end

endmodule
